layer_serializer: RTL and testbench

LAYER_SERIALIZER -- requirements
Module: layer_serializer

---
 rtl/layer_serializer_pkg.sv | 21 ++
 rtl/layer_serializer_argmax_tracker.sv | 65 ++++++
 rtl/layer_serializer.sv | 146 ++++++++++++++
 tb/tb_layer_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_serializer_pkg.sv
// ---------------------------------------------------------------------------
// layer_serializer_pkg
// Shared definitions for the layer serializer: the two-state FSM encoding
// and the helper that sizes the lane index counter.
// No ports (package).
// ---------------------------------------------------------------------------
package layer_serializer_pkg;

  // COLLECT gathers one word per neuron lane; SEND streams them out in order.
  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  // Width of the lane index. A single-lane layer still needs a 1-bit index,
  // because a zero-width vector is not legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_serializer_argmax_tracker.sv
// ---------------------------------------------------------------------------
// argmax_tracker
// Watches the serialized word stream and reports which lane carried the
// largest signed value once the last lane of a layer has been transferred.
// Only instantiated when LAYER_SERIALIZER_ARGMAX_EN is defined.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   word_valid : a word is transferred this cycle
//   word_data  : the transferred word (two's complement)
//   word_idx   : lane index of the transferred word
//   word_last  : the transferred word is the final lane of the layer
//   max_idx    : lane of the largest word of the last completed layer
//   max_valid  : one-cycle pulse, the cycle after the final transfer
// ---------------------------------------------------------------------------
module argmax_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_valid,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic [IDX_W-1:0]      word_idx,
  input  logic                  word_last,
  output logic [IDX_W-1:0]      max_idx,
  output logic                  max_valid
);

  logic [DATA_WIDTH-1:0] best_val;
  logic [IDX_W-1:0]      best_idx;
  logic                  take_new;
  logic [DATA_WIDTH-1:0] cand_val;
  logic [IDX_W-1:0]      cand_idx;

  // Lane 0 always restarts the running maximum, so nothing from the previous
  // layer leaks in. A strictly-greater compare keeps the lower lane on ties.
  always_comb begin
    take_new = (word_idx == '0) || ($signed(word_data) > $signed(best_val));
    cand_val = take_new ? word_data : best_val;
    cand_idx = take_new ? word_idx : best_idx;
  end

  // Running maximum plus the published result. The result is latched on the
  // final transfer from the candidate, so it already includes the last lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_val  <= '0;
      best_idx  <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= word_valid && word_last;
      if (word_valid) begin
        best_val <= cand_val;
        best_idx <= cand_idx;
        if (word_last) begin
          max_idx <= cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// ---------------------------------------------------------------------------
// layer_serializer
// Collects one output word from every neuron lane of a layer, then streams
// the words lane 0 .. NUM_NEURONS-1 over a valid/ready link to the next layer.
// Lanes may arrive in any order and over several cycles; input arriving while
// the block is sending is dropped and flagged in the sticky overflow output.
//
// Optional feature: define LAYER_SERIALIZER_ARGMAX_EN to add max_idx and
// max_valid, which report the lane holding the largest signed word.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_data   : packed lane words, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid  : per-lane valid pulse from each neuron
//   out_data  : serialized word
//   out_valid : out_data is valid
//   out_ready : consumer accepts the word this cycle
//   out_last  : current word is the final lane
//   overflow  : sticky, input arrived while sending
//   max_idx   : (argmax build) lane of the largest word of the last layer
//   max_valid : (argmax build) one-cycle pulse when max_idx is updated
// ---------------------------------------------------------------------------
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              overflow
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  ,
  output logic [idx_width(NUM_NEURONS)-1:0] max_idx,
  output logic                              max_valid
`endif
);

  localparam int              IDX_W    = idx_width(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [NUM_NEURONS-1:0] mask;
  logic [NUM_NEURONS-1:0] mask_next;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_next;
  logic [DATA_WIDTH-1:0]  lane_buf [NUM_NEURONS];
  logic                   transfer;

  // Outputs are decoded straight from the state register so that an
  // asynchronous reset clears them at once, without waiting for an edge.
  always_comb begin
    out_valid = (state == SEND);
    out_data  = out_valid ? lane_buf[idx] : '0;
    out_last  = out_valid && (idx == LAST_IDX);
    transfer  = out_valid && out_ready;
  end

  // Next-state logic. In COLLECT the mask includes this cycle's arrivals, so
  // the last lane to arrive moves us to SEND on the very next edge. In SEND
  // only an accepted word advances the index; the final accept rewinds
  // everything for the next layer.
  always_comb begin
    state_next = state;
    mask_next  = mask;
    idx_next   = idx;
    case (state)
      COLLECT: begin
        mask_next = mask | in_valid;
        if (&mask_next) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (transfer) begin
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            mask_next  = '0;
            state_next = COLLECT;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Control state: FSM, arrival mask and send index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
      mask  <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
      idx   <= idx_next;
    end
  end

  // Anything arriving while sending is lost, including in the final-transfer
  // cycle, so remember that it happened until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if ((state == SEND) && (|in_valid)) begin
      overflow <= 1'b1;
    end
  end

  // Lane storage. Only written while collecting, so words being streamed out
  // can never be disturbed. A repeated lane simply overwrites its slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if ((state == COLLECT) && in_valid[i]) begin
        lane_buf[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef LAYER_SERIALIZER_ARGMAX_EN
  argmax_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .word_valid (transfer),
    .word_data  (out_data),
    .word_idx   (idx),
    .word_last  (out_last),
    .max_idx    (max_idx),
    .max_valid  (max_valid)
  );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// ---------------------------------------------------------------------------
// tb_layer_serializer
// Directed bench for layer_serializer with NUM_NEURONS=4, DATA_WIDTH=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_layer_serializer;

  localparam int NUM_NEURONS = 4;
  localparam int DATA_WIDTH  = 16;

  logic                              clk = 1'b0;
  logic                              rst;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic [NUM_NEURONS-1:0]            in_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic                              out_last;
  logic                              overflow;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  logic [1:0]                        max_idx;
  logic                              max_valid;
`endif

  int errors = 0;
  int checks = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  layer_serializer #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    ,
    .max_idx   (max_idx),
    .max_valid (max_valid)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Valid/last always checked; data only where a word is expected.
  task automatic checkOutput(input string tag, input logic exp_valid,
                             input logic [15:0] exp_data, input logic exp_last);
    checkVal({tag, " valid"}, 32'(out_valid), 32'(exp_valid));
    checkVal({tag, " last"}, 32'(out_last), 32'(exp_last));
    if (exp_valid) begin
      checkVal({tag, " data"}, 32'(out_data), 32'(exp_data));
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2,
                               input logic [15:0] d3);
    in_valid = v;
    in_data  = {d3, d2, d1, d0};
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  // Safety net so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // ---- reset state ----
    #12;
    checkVal("reset out_valid", 32'(out_valid), 32'd0);
    checkVal("reset out_last", 32'(out_last), 32'd0);
    checkVal("reset overflow", 32'(overflow), 32'd0);
    checkVal("reset out_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b1;

    // ---- basic serialization ----
    $display("[TB] basic serialization");
    applyStimulus(4'hF, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    checkOutput("basic c0", 1'b0, 16'h0000, 1'b0);
    tick(); idle();
    checkOutput("basic w1", 1'b1, 16'h0001, 1'b0);
    tick();
    checkOutput("basic w2", 1'b1, 16'h0002, 1'b0);
    tick();
    checkOutput("basic w3", 1'b1, 16'h0003, 1'b0);
    tick();
    checkOutput("basic w4", 1'b1, 16'h0004, 1'b1);
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    checkVal("basic max_valid before", 32'(max_valid), 32'd0);
`endif
    tick();
    checkOutput("basic end", 1'b0, 16'h0000, 1'b0);
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    checkVal("basic max_valid", 32'(max_valid), 32'd1);
    checkVal("basic max_idx", 32'(max_idx), 32'd3);
`endif

    // ---- staggered arrival ----
    $display("[TB] staggered arrival");
    applyStimulus(4'b0011, 16'h0011, 16'h0022, 16'hDEAD, 16'hDEAD);
    checkOutput("stag c0", 1'b0, 16'h0000, 1'b0);
    tick(); idle();
    checkOutput("stag c1", 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("stag c2", 1'b0, 16'h0000, 1'b0);
    applyStimulus(4'b1100, 16'hBEEF, 16'hBEEF, 16'h0033, 16'h0044);
    checkOutput("stag c3", 1'b0, 16'h0000, 1'b0);
    tick(); idle();
    checkOutput("stag w1", 1'b1, 16'h0011, 1'b0);
    tick();
    checkOutput("stag w2", 1'b1, 16'h0022, 1'b0);
    tick();
    checkOutput("stag w3", 1'b1, 16'h0033, 1'b0);
    tick();
    checkOutput("stag w4", 1'b1, 16'h0044, 1'b1);
    tick();
    checkOutput("stag end", 1'b0, 16'h0000, 1'b0);

    // ---- backpressure ----
    $display("[TB] backpressure");
    applyStimulus(4'hF, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    tick(); idle();
    checkOutput("bp w1", 1'b1, 16'h0001, 1'b0);
    tick();
    out_ready = 1'b0;
    checkOutput("bp w2 first", 1'b1, 16'h0002, 1'b0);
    tick();
    checkOutput("bp hold1", 1'b1, 16'h0002, 1'b0);
    tick();
    checkOutput("bp hold2", 1'b1, 16'h0002, 1'b0);
    tick();
    checkOutput("bp hold3", 1'b1, 16'h0002, 1'b0);
    out_ready = 1'b1;
    tick();
    checkOutput("bp w3", 1'b1, 16'h0003, 1'b0);
    tick();
    checkOutput("bp w4", 1'b1, 16'h0004, 1'b1);
    tick();
    checkOutput("bp end", 1'b0, 16'h0000, 1'b0);
    checkVal("bp overflow", 32'(overflow), 32'd0);

    // ---- overflow ----
    $display("[TB] overflow");
    applyStimulus(4'hF, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
    tick(); idle();
    checkOutput("ovf w1", 1'b1, 16'h000A, 1'b0);
    tick();
    checkOutput("ovf w2", 1'b1, 16'h000B, 1'b0);
    tick();
    checkOutput("ovf w3", 1'b1, 16'h000C, 1'b0);
    applyStimulus(4'h1, 16'h9999, 16'h0000, 16'h0000, 16'h0000);
    checkVal("ovf flag before", 32'(overflow), 32'd0);
    tick();
    // Full set offered during the final transfer: must be dropped.
    applyStimulus(4'hF, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
    checkOutput("ovf w4", 1'b1, 16'h000D, 1'b1);
    checkVal("ovf flag set", 32'(overflow), 32'd1);
    tick(); idle();
    checkOutput("ovf dropped1", 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("ovf dropped2", 1'b0, 16'h0000, 1'b0);
    applyStimulus(4'hF, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    tick(); idle();
    checkOutput("ovf next w1", 1'b1, 16'h0005, 1'b0);
    tick();
    checkOutput("ovf next w2", 1'b1, 16'h0006, 1'b0);
    tick();
    checkOutput("ovf next w3", 1'b1, 16'h0007, 1'b0);
    tick();
    checkOutput("ovf next w4", 1'b1, 16'h0008, 1'b1);
    tick();
    checkOutput("ovf next end", 1'b0, 16'h0000, 1'b0);
    checkVal("ovf sticky", 32'(overflow), 32'd1);

    // ---- reset mid-burst ----
    $display("[TB] reset mid-burst");
    applyStimulus(4'hF, 16'h0021, 16'h0022, 16'h0023, 16'h0024);
    tick(); idle();
    checkOutput("rst w1", 1'b1, 16'h0021, 1'b0);
    tick();
    checkOutput("rst w2", 1'b1, 16'h0022, 1'b0);
    tick();
    checkOutput("rst w3", 1'b1, 16'h0023, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkVal("rst async out_valid", 32'(out_valid), 32'd0);
    checkVal("rst async overflow", 32'(overflow), 32'd0);
    checkVal("rst async out_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst quiet1", 1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("rst quiet2", 1'b0, 16'h0000, 1'b0);
    applyStimulus(4'hF, 16'h0031, 16'h0032, 16'h0033, 16'h0034);
    tick(); idle();
    checkOutput("rst fresh w1", 1'b1, 16'h0031, 1'b0);
    tick();
    checkOutput("rst fresh w2", 1'b1, 16'h0032, 1'b0);
    tick();
    checkOutput("rst fresh w3", 1'b1, 16'h0033, 1'b0);
    tick();
    checkOutput("rst fresh w4", 1'b1, 16'h0034, 1'b1);
    tick();
    checkOutput("rst fresh end", 1'b0, 16'h0000, 1'b0);

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    // ---- argmax ----
    $display("[TB] argmax");
    applyStimulus(4'hF, 16'hFFF0, 16'h0100, 16'h0100, 16'h7FFF);
    tick(); idle();
    checkOutput("amax1 w1", 1'b1, 16'hFFF0, 1'b0);
    tick(); tick(); tick();
    checkOutput("amax1 w4", 1'b1, 16'h7FFF, 1'b1);
    tick();
    checkVal("amax1 max_valid", 32'(max_valid), 32'd1);
    checkVal("amax1 max_idx", 32'(max_idx), 32'd3);
    tick();
    checkVal("amax1 pulse end", 32'(max_valid), 32'd0);
    checkVal("amax1 hold idx", 32'(max_idx), 32'd3);
    applyStimulus(4'hF, 16'h0005, 16'h0009, 16'h0009, 16'h8000);
    tick(); idle();
    tick(); tick(); tick();
    checkOutput("amax2 w4", 1'b1, 16'h8000, 1'b1);
    tick();
    checkVal("amax2 max_valid", 32'(max_valid), 32'd1);
    checkVal("amax2 max_idx", 32'(max_idx), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
